// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time to instruction
// memory and hands each instruction with its PC to decode; redirects squash stale fetches.
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic [63:0] fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [63:0] fetch_count_q, fetch_count_d;

  logic [63:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  assign redirect_tgt         = {redirect_pc[63:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshake-visible outputs are pure decodes of registered state, so neither
  // out_ready nor redirect_valid can reach an output combinationally.
  assign imem_req_valid = (state_q == S_REQ);
  assign out_valid      = (state_q == S_HOLD);
  assign imem_req_addr  = pc_q;
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;
  assign fetch_count    = fetch_count_q;

  always_comb begin
    // NOTE: every *_d gets a hold value first so no path through the case
    // statement leaves a signal unassigned, which would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    out_inst_d    = out_inst_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_HOLD;
            out_inst_d = imem_rsp_data;
            out_pc_d   = pc_q;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          fetch_count_d = fetch_count_q + 64'd1;
          pc_d          = pc_q + 64'd4;
          state_d       = S_REQ;
        end
        if (redirect_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides whatever PC update the state logic chose.
    if (redirect_valid) pc_d = redirect_tgt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      out_inst_q    <= 32'd0;
      out_pc_q      <= RESET_PC;
      fetch_count_q <= 64'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      out_inst_q    <= out_inst_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Bench for ysyx_22050612_ifu: directed scenarios then random traffic, compared against
// a transaction-level model that tracks outstanding fetches, squashes and the PC.
module tb_ysyx_22050612_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [63:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Model: m_outst = a request was accepted and its response has not come back;
  // m_stale = that request was made obsolete by a redirect; m_out_valid = an
  // instruction is waiting for decode.
  bit          m_started, m_outst, m_stale, m_out_valid;
  logic [63:0] m_pc, m_req_addr, m_opc, m_count;
  logic [31:0] m_inst;

  ysyx_22050612_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started   = 1'b0;
    m_outst     = 1'b0;
    m_stale     = 1'b0;
    m_out_valid = 1'b0;
    m_pc        = RESET_PC;
    m_req_addr  = RESET_PC;
    m_opc       = RESET_PC;
    m_count     = 64'd0;
    m_inst      = 32'd0;
  endtask

  task automatic check_reset_values();
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, RESET_PC);
    check("rst_fetch_count", fetch_count, 64'd0);
  endtask

  // Advance one clock with the inputs already driven, update the model, then
  // compare the DUT outputs on the following falling edge.
  task automatic tick();
    bit ov_old;
    bit req_exp;
    ov_old  = m_out_valid;
    req_exp = m_started && !m_outst && !m_out_valid;
    @(posedge clk);
    if (!m_started) begin
      m_started = 1'b1;
    end else begin
      if (req_exp && imem_req_ready) begin
        m_outst    = 1'b1;
        m_req_addr = m_pc;
        m_stale    = redirect_valid;
      end else if (m_outst && imem_rsp_valid) begin
        m_outst = 1'b0;
        if (!m_stale && !redirect_valid) begin
          m_out_valid = 1'b1;
          m_inst      = imem_rsp_data;
          m_opc       = m_req_addr;
        end
      end else if (m_outst && redirect_valid) begin
        m_stale = 1'b1;
      end
      if (ov_old && out_ready) begin
        m_count     = m_count + 64'd1;
        m_pc        = m_opc + 64'd4;
        m_out_valid = 1'b0;
      end
      if (ov_old && redirect_valid) m_out_valid = 1'b0;
    end
    if (redirect_valid) m_pc = {redirect_pc[63:2], 2'b00};
    @(negedge clk);
    check("req_valid", imem_req_valid, m_started && !m_outst && !m_out_valid);
    check("req_addr", imem_req_addr, m_pc);
    check("out_valid", out_valid, m_out_valid);
    if (m_out_valid) begin
      check("out_inst", out_inst, m_inst);
      check("out_pc", out_pc, m_opc);
    end
    check("fetch_count", fetch_count, m_count);
  endtask

  task automatic step(input bit rdy, input bit rsp, input logic [31:0] data,
                      input bit oready, input bit redir, input logic [63:0] tgt);
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    out_ready      = oready;
    redirect_valid = redir;
    redirect_pc    = tgt;
    tick();
  endtask

  function automatic logic [31:0] prog_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0000_0013;
      64'h8000_0004: return 32'h0010_0093;
      64'h8000_0008: return 32'h0020_0113;
      default:       return a[33:2] ^ 32'h5a5a_1234;
    endcase
  endfunction

  // Zero-wait memory: always ready, answers the cycle after acceptance.
  task automatic step_auto(input bit oready);
    step(1'b1, m_outst, prog_word(m_req_addr), oready, 1'b0, 64'd0);
  endtask

  // Called on a falling edge; asserts reset between edges and checks it took effect.
  task automatic apply_reset();
    #2;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    apply_reset();

    // Straight-line fetch: IDLE, then three REQ/WAIT/HOLD rounds.
    step_auto(1'b1);
    check("first_req_valid", imem_req_valid, 1'b1);
    check("first_req_addr", imem_req_addr, 64'h8000_0000);
    repeat (9) step_auto(1'b1);
    check("three_per_9cyc", fetch_count, 64'd3);
    check("next_addr", imem_req_addr, 64'h8000_000C);

    // Decode backpressure for five cycles in HOLD.
    repeat (2) step_auto(1'b1);
    repeat (5) step_auto(1'b0);
    check("bp_out_pc", out_pc, 64'h8000_000C);
    step_auto(1'b1);
    check("bp_next_addr", imem_req_addr, 64'h8000_0010);

    // Redirect in WAIT before the response: the response is squashed.
    step_auto(1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_1002);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'd0);
    check("squash_out_valid", out_valid, 1'b0);
    check("squash_req_valid", imem_req_valid, 1'b1);
    check("squash_req_addr", imem_req_addr, 64'h8000_1000);

    // Redirect in HOLD together with out_ready: counted, but PC takes the target.
    repeat (2) step_auto(1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_0100);
    check("hold_redir_count", fetch_count, 64'd5);
    check("hold_redir_addr", imem_req_addr, 64'h8000_0100);

    // PC wraps modulo 2^64.
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_tgt", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (3) step_auto(1'b1);
    check("wrap_addr", imem_req_addr, 64'd0);

    // Reset mid-WAIT; the late response lands in IDLE and must be ignored.
    step_auto(1'b1);
    apply_reset();
    step(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 64'd0);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_addr", imem_req_addr, 64'h8000_0000);
    repeat (3) step_auto(1'b1);
    check("post_rst_count", fetch_count, 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          rdy, rsp, oready, redir;
      logic [63:0] tgt;
      rdy    = ($urandom_range(0, 9) < 7);
      rsp    = m_outst ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      oready = ($urandom_range(0, 9) < 6);
      redir  = ($urandom_range(0, 99) < 8);
      tgt    = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step(rdy, rsp, $urandom, oready, redir, tgt);
      if (i == 1500) begin
        apply_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch unit for the ysyx_22050612 NPC core, directly upstream of the decode stage. Holds the PC, issues one-at-a-time fetch requests to instruction memory over a valid/ready request channel with a separate response channel, and presents each fetched 32-bit instruction with its PC to decode over a valid/ready handshake. Accepts a redirect (jump/branch/trap target) at any time and discards any fetch made stale by it.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  64  fetch address (= PC register)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid, one-cycle pulse
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle redirect strobe
- redirect_pc  in  64  redirect target; bits [1:0] ignored (treated as 0)
- out_valid  out  1  instruction valid to decode
- out_ready  in  1  decode accepts instruction
- out_inst  out  32  instruction to decode
- out_pc  out  64  PC of out_inst
- fetch_count  out  64  count of completed out handshakes

## Operation
- Reset values: state IDLE, pc = RESET_PC, drop = 0, imem_req_valid = 0, imem_req_addr = RESET_PC, out_valid = 0, out_inst = 0, out_pc = RESET_PC, fetch_count = 0.
- States: IDLE, REQ, WAIT, HOLD. imem_req_valid = (state==REQ); out_valid = (state==HOLD); imem_req_addr = pc.
- IDLE -> REQ unconditionally (one cycle after rst_n deasserts).
- REQ: on imem_req_valid & imem_req_ready -> WAIT. Memory samples imem_req_addr only on the handshake cycle.
- WAIT: on imem_rsp_valid: if drop=1, clear drop, -> REQ; else out_inst <= imem_rsp_data, out_pc <= pc, -> HOLD.
- HOLD: on out_valid & out_ready: pc <= pc + 4 (64-bit, wraps modulo 2^64), fetch_count <= fetch_count + 1, -> REQ. out_inst/out_pc stable while out_valid & !out_ready.
- Redirect (highest priority, target = {redirect_pc[63:2], 2'b00}), all cases set pc <= target:
  - REQ, no handshake: stay REQ; imem_req_addr shows target next cycle.
  - REQ, handshake same cycle: -> WAIT with drop <= 1.
  - WAIT, no response: stay WAIT, drop <= 1.
  - WAIT, response same cycle: response discarded, drop <= 0, -> REQ.
  - HOLD: -> REQ, out_valid falls next cycle; if out_ready same cycle the transfer counts (fetch_count increments) but pc takes target, not pc+4.
  - IDLE: pc <= target, -> REQ.
- imem_rsp_valid outside WAIT is ignored. At most one request outstanding.
- rst_n assertion in any state returns immediately (asynchronously) to reset values; an in-flight response arriving after reset release is ignored because state is not WAIT.

## Timing
- Request handshake at cycle N; response earliest N+1; out_valid first high the cycle after the response.
- Zero-wait memory (ready=1, response next cycle) and out_ready=1: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect at cycle N: earliest request to target at N+1.
- No combinational path from out_ready or redirect_valid to any output; all outputs are registered or decoded from state/pc.

## Test plan
- Reset: rst_n=0 then release -> all outputs at reset values; cycle 1 after release imem_req_valid=1, addr=0x80000000.
- Straight-line fetch, ready=1, response next cycle with 0x00000013, 0x00100093, 0x00200113, out_ready=1 -> out_pc 0x80000000/04/08 with matching out_inst, fetch_count=3.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_inst, out_pc stable, no new request; out_ready=1 -> next request at 0x80000004.
- Redirect in WAIT to 0x80001002 before response -> response 0xDEADBEEF discarded, out_valid stays 0, next request addr 0x80001000.
- Redirect in HOLD with out_ready=1 same cycle, target 0x80000100 -> fetch_count increments, next request addr 0x80000100 (not pc+4).
- rst_n pulsed low mid-WAIT, response arrives after release -> response ignored, fetch restarts at 0x80000000, fetch_count=0.
